// File: rtl/bram_pkg.sv
// Shared types and helpers for the banked BRAM (clear FSM encoding, bank packing).
package bram_pkg;

  localparam int MAX_READ_LATENCY = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clrState_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Bit offset of a bank's slice inside the packed wide word.
  function automatic int sliceOffset(input int bank, input int width);
    return bank * width;
  endfunction

endpackage

// File: rtl/bram_bank_core.sv
// One bank: storage array, stage-1 read register and collision forwarding.
// With BRAM_PARITY_EN each word carries an even-parity bit checked at stage 1.
module bram_bank_core
  import bram_pkg::*;
#(
  parameter int    DATA_WIDTH  = 32,
  parameter int    ADDR_WIDTH  = 8,
  parameter int    WRITE_FIRST = 1,
  parameter int    BANK        = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wrEn,
  input  logic [ADDR_WIDTH-1:0] wrAddr,
  input  logic [DATA_WIDTH-1:0] wrData,
  input  logic                  rdEn,
  input  logic [ADDR_WIDTH-1:0] rdAddr,
  output logic [DATA_WIDTH-1:0] rdData
`ifdef BRAM_PARITY_EN
  ,
  output logic                  parErr
`endif
);

`ifdef BRAM_PARITY_EN
  localparam int WORD_W = DATA_WIDTH + 1;
`else
  localparam int WORD_W = DATA_WIDTH;
`endif

  logic [WORD_W-1:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic [WORD_W-1:0] wrWord;
  logic              forward;

`ifdef BRAM_PARITY_EN
  assign wrWord = {^wrData, wrData};
`else
  assign wrWord = wrData;
`endif

  assign forward = (WRITE_FIRST != 0) && wrEn && (wrAddr == rdAddr);

  always_ff @(posedge clock)
    if (wrEn) mem[wrAddr] <= wrWord;

  // A non-accepted read presents zero rather than holding stale data.
  always_ff @(posedge clock or posedge reset)
    if (reset)        rdData <= '0;
    else if (!rdEn)   rdData <= '0;
    else if (forward) rdData <= wrData;
    else              rdData <= mem[rdAddr][DATA_WIDTH-1:0];

`ifdef BRAM_PARITY_EN
  always_ff @(posedge clock or posedge reset)
    if (reset) parErr <= 1'b0;
    else       parErr <= rdEn && !forward && (^mem[rdAddr]);
`endif

endmodule

// File: rtl/bram_banked.sv
// NUM_BANKS parallel banks on shared addresses with clear sweep and read latency pipe.
// Optional BRAM_PARITY_EN adds per-bank parity storage and the parityError port.
module bram_banked
  import bram_pkg::*;
#(
  parameter int    DATA_WIDTH     = 32,
  parameter int    ADDR_WIDTH     = 8,
  parameter int    NUM_BANKS      = 4,
  parameter int    READ_LATENCY   = 1,
  parameter int    WRITE_FIRST    = 1,
  parameter int    CLEAR_ON_RESET = 0,
  parameter string INIT_FILE      = ""
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            clear,
  output logic                            busy,
  input  logic                            readEnable,
  input  logic [ADDR_WIDTH-1:0]           readAddress,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] readData,
  output logic                            readValid,
  input  logic                            writeEnable,
  input  logic [NUM_BANKS-1:0]            writeMask,
  input  logic [ADDR_WIDTH-1:0]           writeAddress,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] writeData
`ifdef BRAM_PARITY_EN
  ,
  output logic [NUM_BANKS-1:0]            parityError
`endif
);

  localparam int WIDTH = NUM_BANKS * DATA_WIDTH;

  clrState_t             state, stateNext;
  logic [ADDR_WIDTH-1:0] sweepAddr, sweepAddrNext;
  logic                  autoStart;
  logic                  clearing;
  logic                  rdAccept;
  logic [ADDR_WIDTH-1:0] bankAddr;
  logic [READ_LATENCY:1] vldPipe;
  wire  [WIDTH-1:0]      stage1Data;

  assign clearing = (state == ST_CLEAR);
  // autoStart covers the first cycle out of reset before the FSM reaches CLEAR.
  assign busy     = clearing || autoStart;
  assign rdAccept = readEnable && !busy;
  assign bankAddr = clearing ? sweepAddr : writeAddress;

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state     <= ST_IDLE;
      sweepAddr <= '0;
      autoStart <= (CLEAR_ON_RESET != 0);
    end else begin
      state     <= stateNext;
      sweepAddr <= sweepAddrNext;
      autoStart <= 1'b0;
    end

  always_comb begin
    stateNext     = state;
    sweepAddrNext = sweepAddr;
    case (state)
      ST_IDLE: begin
        sweepAddrNext = '0;
        if (clear || autoStart) stateNext = ST_CLEAR;
      end
      ST_CLEAR: begin
        sweepAddrNext = sweepAddr + ADDR_WIDTH'(1);
        if (&sweepAddr) stateNext = ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

`ifdef BRAM_PARITY_EN
  localparam int PIPE_W = WIDTH + NUM_BANKS;
  wire [NUM_BANKS-1:0] stage1Par;
`else
  localparam int PIPE_W = WIDTH;
`endif

  generate
    for (genvar b = 0; b < NUM_BANKS; b++) begin : gBank
      localparam int OFS = sliceOffset(b, DATA_WIDTH);
      logic                  bankWe;
      logic [DATA_WIDTH-1:0] bankData;

      assign bankWe   = clearing || (writeEnable && writeMask[b] && !busy);
      assign bankData = clearing ? '0 : writeData[OFS +: DATA_WIDTH];

      bram_bank_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .WRITE_FIRST(WRITE_FIRST),
        .BANK       (b),
        .INIT_FILE  (INIT_FILE)
      ) uCore (
        .clock (clock),
        .reset (reset),
        .wrEn  (bankWe),
        .wrAddr(bankAddr),
        .wrData(bankData),
        .rdEn  (rdAccept),
        .rdAddr(readAddress),
        .rdData(stage1Data[OFS +: DATA_WIDTH])
`ifdef BRAM_PARITY_EN
        ,
        .parErr(stage1Par[b])
`endif
      );
    end
  endgenerate

  always_ff @(posedge clock or posedge reset)
    if (reset) vldPipe <= '0;
    else       vldPipe <= (vldPipe << 1) | READ_LATENCY'(rdAccept);

  assign readValid = vldPipe[READ_LATENCY];

  wire [PIPE_W-1:0] stage1Pipe;
  wire [PIPE_W-1:0] pipeOut;

`ifdef BRAM_PARITY_EN
  assign stage1Pipe  = {stage1Par, stage1Data};
  assign readData    = pipeOut[WIDTH-1:0];
  assign parityError = pipeOut[PIPE_W-1:WIDTH] & {NUM_BANKS{readValid}};
`else
  assign stage1Pipe  = stage1Data;
  assign readData    = pipeOut;
`endif

  // Stages 2..READ_LATENCY are plain delay registers behind the bank cores.
  generate
    if (READ_LATENCY > 1) begin : gDly
      logic [READ_LATENCY-1:1][PIPE_W-1:0] dly;
      always_ff @(posedge clock or posedge reset)
        if (reset) dly <= '0;
        else begin
          dly[1] <= stage1Pipe;
          for (int k = 2; k < READ_LATENCY; k++) dly[k] <= dly[k-1];
        end
      assign pipeOut = dly[READ_LATENCY-1];
    end else begin : gNoDly
      assign pipeOut = stage1Pipe;
    end
  endgenerate

endmodule
